// File: rtl/bsg_link_co_sdr_tx.sv
// bsg_link_co_sdr_tx: credit-based SDR transmitter for the outbound co link channel
//   clk_i/async_reset_n_i : core clock, async active-low reset
//   en_i                  : link enable (IDLE <-> RUN)
//   v_i/data_i/ready_o    : core-side valid/ready word input
//   co_v_o/co_data_o      : registered valid/data to the co pads
//   co_tkn_i              : async token toggle from receiver, each edge returns tkn_decimation_p credits
//   credits_o/err_o       : debug credit count, sticky credit-overflow flag
module bsg_link_co_sdr_tx #(
  parameter int width_p = 9,
  parameter int credits_p = 16,
  parameter int tkn_decimation_p = 4
) (
  input  logic                             clk_i,
  input  logic                             async_reset_n_i,
  input  logic                             en_i,
  input  logic                             v_i,
  input  logic [width_p-1:0]               data_i,
  output logic                             ready_o,
  output logic                             co_v_o,
  output logic [width_p-1:0]               co_data_o,
  input  logic                             co_tkn_i,
  output logic [$clog2(credits_p+1)-1:0]   credits_o,
  output logic                             err_o
);
  localparam int cw = $clog2(credits_p+1);
  typedef enum logic {IDLE, RUN} state_e;
  state_e state, state_n;
  logic tkn_s1, tkn_s2, tkn_h, tkn_edge, send;
  logic [cw:0] credits_n;
  always_ff @(posedge clk_i or negedge async_reset_n_i)
    if (!async_reset_n_i) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = en_i ? RUN : IDLE;
    ready_o = en_i & (state == RUN) & (credits_o != '0);
    send = v_i & ready_o;
    tkn_edge = tkn_s2 ^ tkn_h;
    credits_n = {1'b0, credits_o} - (cw+1)'(send) + (tkn_edge ? (cw+1)'(tkn_decimation_p) : '0);
  end
  always_ff @(posedge clk_i or negedge async_reset_n_i)
    if (!async_reset_n_i) begin
      tkn_s1 <= 1'b0;
      tkn_s2 <= 1'b0;
      tkn_h <= 1'b0;
      co_v_o <= 1'b0;
      co_data_o <= '0;
      credits_o <= cw'(credits_p);
      err_o <= 1'b0;
    end else begin
      tkn_s1 <= co_tkn_i;
      tkn_s2 <= tkn_s1;
      tkn_h <= tkn_s2;
      co_v_o <= send;
      co_data_o <= send ? data_i : co_data_o;
      credits_o <= (credits_n > (cw+1)'(credits_p)) ? cw'(credits_p) : credits_n[cw-1:0];
      err_o <= err_o | (credits_n > (cw+1)'(credits_p));
    end
endmodule

// File: tb/tb_bsg_link_co_sdr_tx.sv
// tb_bsg_link_co_sdr_tx: table-driven self-checking bench for bsg_link_co_sdr_tx
module tb_bsg_link_co_sdr_tx;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, v = 1'b0, tkn = 1'b0;
  logic [8:0] data = '0;
  logic ready, co_v, err;
  logic [8:0] co_data;
  logic [4:0] credits;
  int checks = 0, failures = 0;
  typedef struct {
    logic en, v, t, cv, er, rd;
    logic [8:0] d, cd;
    logic [4:0] cr;
  } vec_t;
  vec_t vq[$];
  bsg_link_co_sdr_tx dut (
    .clk_i(clk), .async_reset_n_i(rst_n), .en_i(en), .v_i(v), .data_i(data),
    .ready_o(ready), .co_v_o(co_v), .co_data_o(co_data), .co_tkn_i(tkn),
    .credits_o(credits), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input int e, input int vv, input int d, input int t,
                              input int cv, input int cd, input int cr, input int er, input int rd);
    vec_t r;
    r.en = 1'(e); r.v = 1'(vv); r.d = 9'(d); r.t = 1'(t);
    r.cv = 1'(cv); r.cd = 9'(cd); r.cr = 5'(cr); r.er = 1'(er); r.rd = 1'(rd);
    vq.push_back(r);
  endfunction
  initial begin
    add(1,0,0,0, 0,0,16,0,1);
    for (int i = 0; i < 16; i++) add(1,1,i,0, 1,i,15-i,0, int'(i < 15));
    add(1,1,'h10,1, 0,'h0f,0,0,0);
    add(1,1,'h10,1, 0,'h0f,0,0,0);
    add(1,1,'h10,1, 0,'h0f,4,0,1);
    for (int j = 0; j < 4; j++) add(1,1,'h10+j,1, 1,'h10+j,3-j,0, int'(j < 3));
    add(1,1,'h14,1, 0,'h13,0,0,0);
    add(1,0,0,0, 0,'h13,0,0,0);
    add(1,0,0,0, 0,'h13,0,0,0);
    add(1,0,0,0, 0,'h13,4,0,1);
    add(1,0,0,1, 0,'h13,4,0,1);
    add(1,0,0,1, 0,'h13,4,0,1);
    add(1,0,0,1, 0,'h13,8,0,1);
    add(1,1,'h20,1, 1,'h20,7,0,1);
    add(1,1,'h21,1, 1,'h21,6,0,1);
    add(1,1,'h22,0, 1,'h22,5,0,1);
    add(1,0,0,0, 0,'h22,5,0,1);
    add(1,1,'h23,0, 1,'h23,8,0,1);
    add(1,1,'h24,0, 1,'h24,7,0,1);
    add(1,1,'h25,0, 1,'h25,6,0,1);
    add(1,0,0,1, 0,'h25,6,0,1);
    add(1,0,0,1, 0,'h25,6,0,1);
    add(1,0,0,1, 0,'h25,10,0,1);
    add(1,0,0,0, 0,'h25,10,0,1);
    add(1,0,0,0, 0,'h25,10,0,1);
    add(1,0,0,0, 0,'h25,14,0,1);
    add(1,0,0,1, 0,'h25,14,0,1);
    add(1,0,0,1, 0,'h25,14,0,1);
    add(1,0,0,1, 0,'h25,16,1,1);
    add(1,0,0,1, 0,'h25,16,1,1);
    for (int k = 0; k < 6; k++) add(1,1,'h30+k,1, 1,'h30+k,15-k,1,1);
    add(0,1,'h36,0, 0,'h35,10,1,0);
    add(0,1,'h36,0, 0,'h35,10,1,0);
    add(0,1,'h36,0, 0,'h35,14,1,0);
    add(0,1,'h36,0, 0,'h35,14,1,0);
    #12;
    chk("reset co_v", 32'(co_v), 0);
    chk("reset co_data", 32'(co_data), 0);
    chk("reset ready", 32'(ready), 0);
    chk("reset credits", 32'(credits), 16);
    chk("reset err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;
    #1;
    chk("ready before enable edge", 32'(ready), 0);
    foreach (vq[i]) begin
      en = vq[i].en; v = vq[i].v; data = vq[i].d; tkn = vq[i].t;
      @(posedge clk);
      #1;
      chk($sformatf("row%0d co_v", i), 32'(co_v), 32'(vq[i].cv));
      chk($sformatf("row%0d co_data", i), 32'(co_data), 32'(vq[i].cd));
      chk($sformatf("row%0d credits", i), 32'(credits), 32'(vq[i].cr));
      chk($sformatf("row%0d err", i), 32'(err), 32'(vq[i].er));
      chk($sformatf("row%0d ready", i), 32'(ready), 32'(vq[i].rd));
    end
    en = 1'b1; v = 1'b0;
    @(posedge clk);
    #1;
    chk("reenable ready", 32'(ready), 1);
    chk("reenable credits", 32'(credits), 14);
    v = 1'b1; data = 9'h13a;
    @(posedge clk);
    #1;
    chk("inflight co_v", 32'(co_v), 1);
    chk("inflight co_data", 32'(co_data), 'h13a);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midreset co_v", 32'(co_v), 0);
    chk("midreset credits", 32'(credits), 16);
    chk("midreset err", 32'(err), 0);
    chk("midreset co_data", 32'(co_data), 0);
    chk("midreset ready", 32'(ready), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bsg_link_co_sdr_tx.md
# bsg_link_co_sdr_tx

Credit-based single-data-rate transmitter for the outbound chip-to-chip link channel (co). It accepts 9-bit words from the core over valid/ready and launches them registered onto the padring's co valid/data pad inputs. It tracks receiver buffer space with a credit counter, replenished by toggles on the co token pad output. The forwarded co clock is generated by the clock block and is outside this block.

## Interface
- width_p, 9: link data width (matches co pad count).
- credits_p, 16: receiver buffer depth; reset credit count.
- tkn_decimation_p, 4: credits returned per token edge; must divide credits_p.
- clk_i  in  1  link core clock; all state on its rising edge.
- async_reset_n_i  in  1  asynchronous, active-low reset. Assertion is asynchronous; deassertion is synchronized to clk_i by the clock/reset block.
- en_i  in  1  link enable from the bsg_tag-configured control.
- v_i  in  1  core word valid.
- data_i  in  width_p  core word.
- ready_o  out  1  block accepts data_i this cycle.
- co_v_o  out  1  registered valid to the co valid pad.
- co_data_o  out  width_p  registered data to the co data pads.
- co_tkn_i  in  1  token from the co token pad; asynchronous to clk_i.
- credits_o  out  $clog2(credits_p+1)  current credit count, for debug.
- err_o  out  1  sticky credit-overflow flag.

## Operation
- **States:** IDLE, RUN; reset to IDLE.
  - IDLE → RUN when en_i=1.
  - RUN → IDLE when en_i=0.
- **Ready:** ready_o = en_i & (state==RUN) & (credits != 0). It is combinational from en_i, state and credits only, never from v_i.
- **Send:** send = v_i & ready_o.
  - On send, the next cycle has co_v_o=1 and co_data_o=data_i.
  - With no send, the next cycle has co_v_o=0 and co_data_o holds its last value.
- **Token path:**
  - co_tkn_i passes through a 2-flop synchronizer, then one history flop.
  - tkn_edge = sync_out XOR history; both rising and falling edges count.
- **Credit update (one cycle):** next = credits - send + (tkn_edge ? tkn_decimation_p : 0).
  - Arithmetic is in width $clog2(credits_p+1)+1 so intermediate values do not wrap.
  - If next > credits_p, credits saturate at credits_p and err_o is set. err_o clears only on reset.
- **Credit floor:** credits never go below 0, because send requires credits != 0.
- **IDLE behaviour:** token edges are still counted, credits are preserved, and no words are sent.
- **Dropping en_i mid-stream:** no send occurs in the cycle en_i=0. A word already registered still appears on co_v_o for its one cycle.
- **Reset mid-operation:** all state returns to reset values immediately (asynchronous). An in-flight co_v_o pulse is cut.
- **Token-rate limit:** the remote side toggles co_tkn_i at most once per 3 clk_i cycles, so no edges are lost.

## Timing
- **Reset values:**
  - co_v_o=0, co_data_o=0, err_o=0, ready_o=0.
  - state=IDLE; credits_o=credits_p.
  - Synchronizer and history flops = 0.
- **Data latency:** handshake at cycle N → co_v_o/co_data_o valid in cycle N+1, held for exactly one cycle.
- **Token latency:** a co_tkn_i edge settled before clock edge K raises credits_o after edge K+2, i.e. visible in cycle K+3. A tkn_edge in cycle K+2 can enable a send in that same cycle only if credits were already nonzero.
- **Enable latency:** en_i rise in cycle N → ready_o can first be 1 in cycle N+1.
- **Throughput:** one word per cycle while credits != 0.
- **Simultaneous send and token edge:** the net change is applied in the same cycle (e.g. 5 → 8 with decimation 4).

## Test plan
- **Reset:** hold async_reset_n_i=0 mid-cycle, release.
  - Required: co_v_o=0, co_data_o=0, ready_o=0, credits_o=16, err_o=0.
  - Required: ready_o=1 the cycle after en_i=1.
- **Credit exhaustion:** en_i=1, v_i=1 continuously, data 0x000..0x00F, no tokens.
  - Required: exactly 16 words appear on co_v_o/co_data_o in order.
  - Required: ready_o=0 after the 16th handshake; credits_o=0.
- **Token return:** from credits 0, toggle co_tkn_i once.
  - Required: credits_o=4 three cycles later; the next 4 words are sent, then ready_o=0.
  - Toggle twice more, spaced 3 cycles apart: credits reach 8.
- **Simultaneous events:** at credits 5, a send coincides with a tkn_edge.
  - Required: credits_o=8 the next cycle, and the word is on co_data_o.
- **Overflow:** at credits 14 with no sends, toggle co_tkn_i.
  - Required: credits_o=16 (saturated), err_o=1 and stays 1 until reset.
- **Enable drop and reset mid-stream:**
  - Drop en_i during a burst: no handshake in that cycle, state goes to IDLE, credits are preserved, and tokens are still counted in IDLE.
  - Assert reset while co_v_o=1: co_v_o=0 immediately and credits_o=16.
